// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch
// Purpose  : Instruction fetch unit. Owns the program counter, presents it to
//            the instruction memory, captures the returned word into a
//            one-entry output register and hands it to decode over a
//            valid/ready handshake. Handles redirects, flags misaligned
//            redirect targets and halts at the end of the memory image.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            pc_out              - fetch address to instruction memory
//            inst_code           - combinational read data for pc_out
//            redirect_valid/pc   - branch/jump redirect request and target
//            inst_valid/inst/
//            inst_pc/inst_ready  - decode-side handshake and payload
//            fetch_done          - fetch has reached end of image (HALT)
//            misalign_err        - misaligned redirect seen (sticky, ERR)
//            fetch_count         - completed decode handshakes since reset
// Revision : 1.0 - initial release
// ============================================================================
module inst_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int          MEM_BYTES = 32
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc_out,
    input  logic [31:0] inst_code,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    output logic        fetch_done,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    localparam logic [1:0]  c_st_fetch = 2'd0;
    localparam logic [1:0]  c_st_halt  = 2'd1;
    localparam logic [1:0]  c_st_err   = 2'd2;

    localparam logic [31:0] c_mem_end  = 32'(MEM_BYTES);
    localparam logic [31:0] c_last_pc  = c_mem_end - 32'd4;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;

    logic [31:0] r_pc;
    logic        r_inst_valid;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic        r_fetch_done;
    logic        r_misalign_err;
    logic [31:0] r_fetch_count;

    logic        w_free;
    logic        w_handshake;
    logic        w_redirect_take;
    logic        w_redirect_misaligned;
    logic        w_redirect_load;
    logic        w_capture;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_fetch;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic. A redirect outranks the normal fetch progression;
    // ERR can only be left through reset.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_fetch, c_st_halt: begin
                if (redirect_valid) begin
                    if (redirect_pc[1:0] != 2'b00) begin
                        w_state_nxt = c_st_err;
                    end else if (redirect_pc >= c_mem_end) begin
                        w_state_nxt = c_st_halt;
                    end else begin
                        w_state_nxt = c_st_fetch;
                    end
                end else if ((r_state == c_st_fetch) && w_free && (r_pc == c_last_pc)) begin
                    // Last word of the image is being captured now.
                    w_state_nxt = c_st_halt;
                end
            end
            c_st_err: begin
                w_state_nxt = c_st_err;
            end
            default: begin
                w_state_nxt = c_st_fetch;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Control decode for the datapath registers
    // ------------------------------------------------------------------------
    always_comb begin
        w_free                = ~r_inst_valid | inst_ready;
        w_handshake           = r_inst_valid & inst_ready;
        w_redirect_take       = redirect_valid & (r_state != c_st_err);
        w_redirect_misaligned = redirect_pc[1:0] != 2'b00;
        w_redirect_load       = w_redirect_take & ~w_redirect_misaligned;
        w_capture             = (r_state == c_st_fetch) & ~redirect_valid & w_free;
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc           <= RESET_PC;
            r_inst_valid   <= 1'b0;
            r_inst         <= 32'h0;
            r_inst_pc      <= 32'h0;
            r_fetch_done   <= 1'b0;
            r_misalign_err <= 1'b0;
            r_fetch_count  <= 32'h0;
        end else begin
            if (w_redirect_load) begin
                r_pc <= redirect_pc;
            end else if (w_capture) begin
                r_pc <= r_pc + 32'd4;
            end

            // A redirect flushes the output register even if decode is
            // accepting it this cycle; the accepted word still counts.
            if (w_redirect_take) begin
                r_inst_valid <= 1'b0;
            end else if (w_capture) begin
                r_inst_valid <= 1'b1;
            end else if (w_handshake) begin
                r_inst_valid <= 1'b0;
            end

            if (w_capture) begin
                r_inst    <= inst_code;
                r_inst_pc <= r_pc;
            end

            if (w_handshake) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end

            // Registered decodes of the state being entered.
            r_fetch_done   <= (w_state_nxt == c_st_halt);
            r_misalign_err <= (w_state_nxt == c_st_err);
        end
    end

    assign pc_out       = r_pc;
    assign inst_valid   = r_inst_valid;
    assign inst         = r_inst;
    assign inst_pc      = r_inst_pc;
    assign fetch_done   = r_fetch_done;
    assign misalign_err = r_misalign_err;
    assign fetch_count  = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch
// Purpose  : Self-checking bench for inst_fetch: directed scenarios with
//            known instruction words, then randomized traffic, all compared
//            against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

    localparam int MEM_BYTES = 32;

    logic        clk;
    logic        reset;
    logic [31:0] pc_out;
    logic [31:0] inst_code;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        fetch_done;
    logic        misalign_err;
    logic [31:0] fetch_count;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] mem [0:7];

    // Reference model state
    int unsigned m_pc;
    bit          m_valid;
    logic [31:0] m_inst;
    int unsigned m_inst_pc;
    int          m_mode;      // 0 = fetching, 1 = halted, 2 = error
    int unsigned m_count;

    inst_fetch #(
        .RESET_PC  (32'h0),
        .MEM_BYTES (MEM_BYTES)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pc_out         (pc_out),
        .inst_code      (inst_code),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .fetch_done     (fetch_done),
        .misalign_err   (misalign_err),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: combinational read, junk outside the image.
    always_comb begin
        inst_code = 32'hdead_beef;
        if (pc_out < 32'(MEM_BYTES)) begin
            inst_code = mem[pc_out[4:2]];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input int unsigned addr);
        return mem[addr / 4];
    endfunction

    task automatic model_reset();
        m_pc      = 0;
        m_valid   = 0;
        m_inst    = 32'h0;
        m_inst_pc = 0;
        m_mode    = 0;
        m_count   = 0;
    endtask

    // One clock of the fetch unit's observable behaviour.
    task automatic model_step(input bit rv, input int unsigned rpc, input bit rdy);
        bit accepted;
        accepted = m_valid && rdy;
        if (accepted) m_count++;
        if (m_mode != 2 && rv) begin
            m_valid = 0;
            if (rpc % 4 != 0) begin
                m_mode = 2;
            end else begin
                m_pc   = rpc;
                m_mode = (rpc >= MEM_BYTES) ? 1 : 0;
            end
        end else if (m_mode == 0 && (!m_valid || rdy)) begin
            m_inst    = mem_word(m_pc);
            m_inst_pc = m_pc;
            m_valid   = 1;
            m_pc      = m_pc + 4;
            if (m_pc == MEM_BYTES) m_mode = 1;
        end else if (accepted) begin
            m_valid = 0;
        end
    endtask

    task automatic compare_all();
        check("pc_out",       pc_out,               m_pc);
        check("inst_valid",   32'(inst_valid),      32'(m_valid));
        check("inst",         inst,                 m_inst);
        check("inst_pc",      inst_pc,              m_inst_pc);
        check("fetch_done",   32'(fetch_done),      32'(m_mode == 1));
        check("misalign_err", 32'(misalign_err),    32'(m_mode == 2));
        check("fetch_count",  fetch_count,          m_count);
    endtask

    // Drive one cycle of inputs, advance the model, then compare after the edge.
    task automatic cycle(input bit rst, input bit rv, input logic [31:0] rpc, input bit rdy);
        @(negedge clk);
        reset          = rst;
        redirect_valid = rv;
        redirect_pc    = rpc;
        inst_ready     = rdy;
        @(posedge clk);
        if (rst) model_reset();
        else     model_step(rv, rpc, rdy);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        logic [31:0] exp_words [0:7];
        logic [31:0] rpc;
        int          sel;

        mem[0] = 32'h00940333; mem[1] = 32'h413903b3;
        mem[2] = 32'h035a02b3; mem[3] = 32'h017b4e33;
        mem[4] = 32'h019c1eb3; mem[5] = 32'h01bd5f33;
        mem[6] = 32'h00d67fb3; mem[7] = 32'h00f768b3;
        exp_words[0] = 32'h00940333; exp_words[1] = 32'h413903b3;
        exp_words[2] = 32'h035a02b3; exp_words[3] = 32'h017b4e33;
        exp_words[4] = 32'h019c1eb3; exp_words[5] = 32'h01bd5f33;
        exp_words[6] = 32'h00d67fb3; exp_words[7] = 32'h00f768b3;

        reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
        model_reset();

        // Reset state
        do_reset();
        check("rst_pc",    pc_out,           32'h0);
        check("rst_valid", 32'(inst_valid),  32'h0);
        check("rst_count", fetch_count,      32'h0);

        // Streaming with decode always ready
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b1);
            check("stream_inst",    inst,    exp_words[i]);
            check("stream_inst_pc", inst_pc, 32'(i * 4));
        end
        check("stream_last_done", 32'(fetch_done), 32'h1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("stream_end_valid", 32'(inst_valid), 32'h0);
        check("stream_end_done",  32'(fetch_done), 32'h1);
        check("stream_end_count", fetch_count,     32'd8);

        // Backpressure holds the register and the PC
        do_reset();
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 32'h0, 1'b0);
            check("bp_inst", inst,    32'h413903b3);
            check("bp_pc",   pc_out,  32'd8);
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("bp_release_inst", inst,    32'h035a02b3);
        check("bp_release_ipc",  inst_pc, 32'd8);

        // Redirect mid-stream: one bubble, then the target
        do_reset();
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b1, 32'd24, 1'b1);
        check("redir_bubble", 32'(inst_valid), 32'h0);
        check("redir_pc",     pc_out,          32'd24);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("redir_first",  inst, 32'h00d67fb3);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("redir_second", inst, 32'h00f768b3);
        check("redir_halt",   32'(fetch_done), 32'h1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);

        // Resume from HALT
        cycle(1'b0, 1'b1, 32'd8, 1'b1);
        check("resume_done", 32'(fetch_done), 32'h0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("resume_inst", inst, 32'h035a02b3);
        cycle(1'b0, 1'b1, 32'd40, 1'b1);
        check("far_done",  32'(fetch_done), 32'h1);
        check("far_valid", 32'(inst_valid), 32'h0);
        check("far_pc",    pc_out,          32'd40);

        // Misaligned redirect is sticky until reset
        cycle(1'b0, 1'b1, 32'd6, 1'b1);
        check("mis_err",   32'(misalign_err), 32'h1);
        check("mis_pc",    pc_out,            32'd40);
        cycle(1'b0, 1'b1, 32'd0, 1'b1);
        check("mis_ignore_redirect", pc_out, 32'd40);
        check("mis_still_err", 32'(misalign_err), 32'h1);
        do_reset();
        check("mis_reset_err", 32'(misalign_err), 32'h0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("mis_restart", inst, 32'h00940333);

        // Handshake and redirect in the same cycle
        do_reset();
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        cycle(1'b0, 1'b1, 32'd16, 1'b1);
        check("sim_count", fetch_count,     32'd1);
        check("sim_flush", 32'(inst_valid), 32'h0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1);
        check("sim_target", inst, 32'h019c1eb3);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 400; i++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0:       rpc = 32'($urandom_range(0, 7)) * 4;
                1:       rpc = 32'($urandom_range(8, 12)) * 4;
                default: rpc = 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(1, 3));
            endcase
            cycle(($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 5) == 0) && (sel != 9 || $urandom_range(0, 3) == 0),
                  rpc,
                  ($urandom_range(0, 3) != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
